// File: rtl/updown_sweep_pkg.sv
// ---------------------------------------------------------------------------
// updown_sweep_pkg
//   Shared definitions for the triangle-sweep sequencer that drives the 4-bit
//   UpDownCounter: default widths and the controller state encoding.
// ---------------------------------------------------------------------------
package updown_sweep_pkg;

    // Default widths; WIDTH matches the UpDownCounter data path.
    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_DWELL_W = 4;
    localparam int unsigned DEF_SWEEP_W = 8;

    // Sequencer states. IDLE must stay the reset state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        TOP_HOLD = 3'd2,
        DOWN     = 3'd3,
        BOT_HOLD = 3'd4
    } sweepState_t;

endpackage

// File: rtl/updown_sweep_controller_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
//   Loadable down-counter timing the hold at either extreme of a sweep.
//   One instance is shared by TOP_HOLD and BOT_HOLD since they never overlap.
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-low reset
//   Load      in   load LoadValue on this edge (takes priority over counting)
//   LoadValue in   dwell length in cycles
//   Value     out  current dwell count (stops at zero)
//   Expire    out  high while Value == 1, i.e. on the last hold cycle
// ---------------------------------------------------------------------------
module dwell_timer
    import updown_sweep_pkg::*;
#(
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Load,
    input  logic [DWELL_W-1:0] LoadValue,
    output logic [DWELL_W-1:0] Value,
    output logic               Expire
);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Value <= '0;
        end else if (Load) begin
            Value <= LoadValue;
        end else if (Value != '0) begin
            Value <= Value - 1'b1;
        end
    end

    assign Expire = (Value == DWELL_W'(1));

endmodule

// File: rtl/updown_sweep_controller.sv
// ---------------------------------------------------------------------------
// updown_sweep_controller
//   Sequences the external UpDownCounter through triangle sweeps
//   LowerLimit -> UpperLimit -> LowerLimit, optionally dwelling at each
//   extreme, for a programmed number of sweeps or continuously (Sweeps = 0).
//   The counter counts every edge unless LoadCount is high; holds are done by
//   reloading the current extreme each cycle. All outputs are Moore.
//
// Ports:
//   Clock         in   rising-edge clock
//   Reset         in   asynchronous active-low reset
//   Start         in   begin a sequence (honoured in IDLE only)
//   Stop          in   abort; beats Start and every other transition
//   LowerLimit    in   bottom of sweep (latched at Start)
//   UpperLimit    in   top of sweep (latched at Start)
//   DwellCycles   in   extra hold cycles at each extreme (latched at Start)
//   Sweeps        in   number of triangles, 0 = run forever (latched)
//   CounterOutput in   current counter value
//   UpDown        out  1 = count up, 0 = count down
//   LoadCount     out  load request to the counter
//   CounterLoad   out  value loaded into the counter
//   Busy          out  high in every state except IDLE
//   Done          out  one-cycle pulse after the final sweep
//   ConfigError   out  one-cycle pulse when Start is rejected
// ---------------------------------------------------------------------------
module updown_sweep_controller
    import updown_sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DWELL_W = DEF_DWELL_W,
    parameter int unsigned SWEEP_W = DEF_SWEEP_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic [WIDTH-1:0]   LowerLimit,
    input  logic [WIDTH-1:0]   UpperLimit,
    input  logic [DWELL_W-1:0] DwellCycles,
    input  logic [SWEEP_W-1:0] Sweeps,
    input  logic [WIDTH-1:0]   CounterOutput,
    output logic               UpDown,
    output logic               LoadCount,
    output logic [WIDTH-1:0]   CounterLoad,
    output logic               Busy,
    output logic               Done,
    output logic               ConfigError
);

    sweepState_t        state;
    sweepState_t        nextState;

    logic [WIDTH-1:0]   lowerLatch;
    logic [WIDTH-1:0]   upperLatch;
    logic [DWELL_W-1:0] dwellLatch;
    logic [SWEEP_W-1:0] sweepsLeft;
    logic               continuous;
    logic               doneReg;
    logic               cfgErrReg;

    logic               startReq;
    logic               limitsOk;
    logic               acceptStart;
    logic               rejectStart;
    logic               atTop;
    logic               atBottom;
    logic               hasDwell;
    logic               lastSweep;

    logic               dwellLoad;
    logic               sweepDone;
    logic               finish;

    logic [DWELL_W-1:0] dwellValue;
    logic               dwellExpire;

    // -----------------------------------------------------------------------
    // Decode of inputs and latched configuration
    // -----------------------------------------------------------------------
    assign startReq = Start && !Stop;

    // UpperLimit >= LowerLimit + 2, evaluated one bit wider so it cannot wrap.
    assign limitsOk = ({1'b0, UpperLimit} >=
                       ({1'b0, LowerLimit} + (WIDTH + 1)'(2)));

    assign acceptStart = (state == IDLE) && startReq && limitsOk;
    assign rejectStart = (state == IDLE) && startReq && !limitsOk;

    // Compare against the value one short of the extreme: the counter
    // reaches the extreme on the same edge that the state changes.
    assign atTop     = (CounterOutput == (upperLatch - 1'b1));
    assign atBottom  = (CounterOutput == (lowerLatch + 1'b1));
    assign hasDwell  = (dwellLatch != '0);
    assign lastSweep = !continuous && (sweepsLeft == SWEEP_W'(1));

    // -----------------------------------------------------------------------
    // Hold timer, loaded on the edge that enters either hold state
    // -----------------------------------------------------------------------
    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) uDwellTimer (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (dwellLoad),
        .LoadValue (dwellLatch),
        .Value     (dwellValue),
        .Expire    (dwellExpire)
    );

    // -----------------------------------------------------------------------
    // State register and configuration latches
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            lowerLatch <= '0;
            upperLatch <= '0;
            dwellLatch <= '0;
            sweepsLeft <= '0;
            continuous <= 1'b0;
            doneReg    <= 1'b0;
            cfgErrReg  <= 1'b0;
        end else begin
            state     <= nextState;
            doneReg   <= finish;
            cfgErrReg <= rejectStart;

            if (acceptStart) begin
                lowerLatch <= LowerLimit;
                upperLatch <= UpperLimit;
                dwellLatch <= DwellCycles;
                sweepsLeft <= Sweeps;
                continuous <= (Sweeps == '0);
            end else if (sweepDone && !continuous) begin
                sweepsLeft <= sweepsLeft - 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        nextState = state;
        dwellLoad = 1'b0;
        sweepDone = 1'b0;
        finish    = 1'b0;

        unique case (state)
            IDLE: begin
                if (acceptStart) begin
                    nextState = UP;
                end
            end
            UP: begin
                if (atTop) begin
                    if (hasDwell) begin
                        nextState = TOP_HOLD;
                        dwellLoad = 1'b1;
                    end else begin
                        nextState = DOWN;
                    end
                end
            end
            TOP_HOLD: begin
                if (dwellExpire) begin
                    nextState = DOWN;
                end
            end
            DOWN: begin
                if (atBottom) begin
                    sweepDone = 1'b1;
                    if (lastSweep) begin
                        nextState = IDLE;
                        finish    = 1'b1;
                    end else if (hasDwell) begin
                        nextState = BOT_HOLD;
                        dwellLoad = 1'b1;
                    end else begin
                        nextState = UP;
                    end
                end
            end
            BOT_HOLD: begin
                if (dwellExpire) begin
                    nextState = UP;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // Abort overrides whatever the sweep logic decided, including Done.
        if ((state != IDLE) && Stop) begin
            nextState = IDLE;
            dwellLoad = 1'b0;
            sweepDone = 1'b0;
            finish    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        UpDown      = 1'b0;
        LoadCount   = 1'b0;
        CounterLoad = lowerLatch;

        unique case (state)
            IDLE: begin
                // Park the counter on the live lower limit.
                LoadCount   = 1'b1;
                CounterLoad = LowerLimit;
            end
            UP: begin
                UpDown = 1'b1;
            end
            TOP_HOLD: begin
                LoadCount   = 1'b1;
                CounterLoad = upperLatch;
            end
            DOWN: begin
                UpDown = 1'b0;
            end
            BOT_HOLD: begin
                LoadCount   = 1'b1;
                CounterLoad = lowerLatch;
            end
            default: begin
                LoadCount   = 1'b1;
                CounterLoad = LowerLimit;
            end
        endcase
    end

    assign Busy        = (state != IDLE);
    assign Done        = doneReg;
    assign ConfigError = cfgErrReg;

endmodule
